// File: rtl/c_shift_pkg.sv
// Shared constants, state encoding and helper for the symbol shift register.
package c_shift_pkg;

    // Shift direction selections
    localparam int unsigned SHIFT_LSB_TO_MSB = 0;
    localparam int unsigned SHIFT_MSB_TO_LSB = 1;
    localparam int unsigned SHIFT_BIDIR      = 2;

    // Fill source selections
    localparam int unsigned FILL_ZEROS = 0;
    localparam int unsigned FILL_ONES  = 1;
    localparam int unsigned FILL_LSB   = 2;
    localparam int unsigned FILL_MSB   = 3;
    localparam int unsigned FILL_WRAP  = 4;
    localparam int unsigned FILL_SDIN  = 5;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StShift = 1'b1
    } state_e;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/c_shift_fill_sel.sv
// Selects the symbol shifted into the vacated end of the register.
module c_shift_fill_sel
    import c_shift_pkg::*;
#(
    parameter int unsigned C_SYM_WIDTH = 1,
    parameter int unsigned C_FILL_DATA = 5
) (
    input  logic [C_SYM_WIDTH-1:0] sym_hi,   // top symbol of the register
    input  logic [C_SYM_WIDTH-1:0] sym_lo,   // bottom symbol of the register
    input  logic [C_SYM_WIDTH-1:0] sdin,
    input  logic                   dir_l2m,  // latched direction, 1 = lsb_to_msb
    output logic [C_SYM_WIDTH-1:0] fill
);

    // Fill mux; wrap re-inserts the symbol currently leaving the register.
    always_comb begin
        fill = '0;
        case (C_FILL_DATA)
            FILL_ZEROS: fill = '0;
            FILL_ONES:  fill = '1;
            FILL_LSB:   fill = {C_SYM_WIDTH{sym_lo[0]}};
            FILL_MSB:   fill = {C_SYM_WIDTH{sym_hi[C_SYM_WIDTH-1]}};
            FILL_WRAP:  fill = dir_l2m ? sym_hi : sym_lo;
            FILL_SDIN:  fill = sdin;
            default:    fill = '0;
        endcase
    end

endmodule

// File: rtl/c_shift_sym_fd_v6_0.sv
// Symbol shift register: parallel load via valid/ready, C_SYM_WIDTH bits out per step.
module c_shift_sym_fd_v6_0
    import c_shift_pkg::*;
#(
    parameter int unsigned           C_WIDTH         = 16,
    parameter int unsigned           C_SYM_WIDTH     = 1,
    parameter int unsigned           C_SHIFT_TYPE    = 0,
    parameter int unsigned           C_FILL_DATA     = 5,
    parameter logic [C_WIDTH-1:0]    C_AINIT_VAL     = '0,
    parameter logic [C_WIDTH-1:0]    C_SINIT_VAL     = '0,
    parameter int unsigned           C_SYNC_PRIORITY = 1,
    parameter int unsigned           C_HAS_CE        = 0,
    localparam int unsigned          N_STEPS         = C_WIDTH / C_SYM_WIDTH,
    localparam int unsigned          CNT_W           = (clog2(N_STEPS) < 1) ? 1 : clog2(N_STEPS)
) (
    input  logic                   CLK,
    input  logic                   ARESETN,
    input  logic                   CE,
    input  logic                   SCLR,
    input  logic                   SINIT,
    input  logic                   LSB_2_MSB,
    input  logic [C_WIDTH-1:0]     D,
    input  logic                   LOAD_VALID,
    output logic                   LOAD_READY,
    input  logic [C_SYM_WIDTH-1:0] SDIN,
    input  logic                   SHIFT_EN,
    output logic [C_SYM_WIDTH-1:0] SDOUT,
    output logic                   SDOUT_VALID,
    output logic [C_WIDTH-1:0]     Q,
    output logic [CNT_W-1:0]       COUNT,
    output logic                   DONE
);

    if ((C_WIDTH % C_SYM_WIDTH) != 0 || C_FILL_DATA > FILL_SDIN || C_SHIFT_TYPE > SHIFT_BIDIR)
    begin : g_param_err
        $error("c_shift_sym_fd_v6_0: illegal parameter combination");
    end

    state_e               state_q, state_d;
    logic [C_WIDTH-1:0]   q_q, q_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 done_q, done_d;
    logic                 dir_q, dir_d;      // 1 = lsb_to_msb

    logic                 ce;
    logic                 last;
    logic                 load;
    logic                 step;
    logic                 load_dir;
    logic                 clr_wins;
    logic [C_SYM_WIDTH-1:0] sym_hi, sym_lo, fill;
    logic [C_WIDTH-1:0]   shifted;

    assign ce       = (C_HAS_CE != 0) ? CE : 1'b1;
    assign last     = (count_q == CNT_W'(N_STEPS - 1));
    assign sym_hi   = q_q[C_WIDTH-1 -: C_SYM_WIDTH];
    assign sym_lo   = q_q[C_SYM_WIDTH-1:0];
    assign load_dir = (C_SHIFT_TYPE == SHIFT_BIDIR) ? LSB_2_MSB
                                                    : (C_SHIFT_TYPE == SHIFT_LSB_TO_MSB);
    // SCLR loses to SINIT only when both are asserted and priority is 0.
    assign clr_wins = SCLR & ((C_SYNC_PRIORITY != 0) | ~SINIT);

    // Ready on the final step lets the next word load with no idle cycle.
    assign LOAD_READY = (state_q == StIdle) ? 1'b1 : (SHIFT_EN & last);
    assign load       = LOAD_VALID & LOAD_READY & ce;
    assign step       = (state_q == StShift) & SHIFT_EN & ce;

    c_shift_fill_sel #(
        .C_SYM_WIDTH (C_SYM_WIDTH),
        .C_FILL_DATA (C_FILL_DATA)
    ) u_fill_sel (
        .sym_hi  (sym_hi),
        .sym_lo  (sym_lo),
        .sdin    (SDIN),
        .dir_l2m (dir_q),
        .fill    (fill)
    );

    if (N_STEPS == 1) begin : g_single
        assign shifted = fill;
    end else begin : g_multi
        assign shifted = dir_q ? {q_q[C_WIDTH-C_SYM_WIDTH-1:0], fill}
                               : {fill, q_q[C_WIDTH-1:C_SYM_WIDTH]};
    end

    // Next-state: sync clear/init, then load, then step; everything holds otherwise.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        count_d = count_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        if (SCLR | SINIT) begin
            q_d     = clr_wins ? '0 : C_SINIT_VAL;
            state_d = StIdle;
            count_d = '0;
        end else begin
            done_d = step & last;
            if (load) begin
                q_d     = D;
                count_d = '0;
                dir_d   = load_dir;
                state_d = StShift;
            end else if (step) begin
                q_d = shifted;
                if (last) begin
                    count_d = '0;
                    state_d = StIdle;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
        end
    end

    // State register with asynchronous abort of the current word.
    always_ff @(posedge CLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= StIdle;
            q_q     <= C_AINIT_VAL;
            count_q <= '0;
            done_q  <= 1'b0;
            dir_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            count_q <= count_d;
            done_q  <= done_d;
            dir_q   <= dir_d;
        end
    end

    assign Q           = q_q;
    assign SDOUT       = dir_q ? sym_hi : sym_lo;
    assign SDOUT_VALID = (state_q == StShift);
    assign COUNT       = count_q;
    assign DONE        = done_q;

endmodule

// File: tb/tb_c_shift_sym_fd_v6_0.sv
// Bench for c_shift_sym_fd_v6_0: three W=8/S=2 variants driven by shared stimulus.
module tb_c_shift_sym_fd_v6_0;

    localparam int NS = 4;  // steps per word

    logic       CLK;
    logic       ARESETN;
    logic       CE;
    logic       SCLR;
    logic       SINIT;
    logic       LSB_2_MSB;
    logic [7:0] D;
    logic       LOAD_VALID;
    logic [1:0] SDIN;
    logic       SHIFT_EN;

    logic       rdy_w  [3];
    logic [1:0] sdout_w[3];
    logic       vld_w  [3];
    logic [7:0] q_w    [3];
    logic [1:0] cnt_w  [3];
    logic       done_w [3];

    int n_checks = 0;
    int n_fail   = 0;

    // Per-instance configuration, mirrored by the reference model
    int p_type [3] = '{0, 1, 2};
    int p_fill [3] = '{0, 4, 5};
    int p_ainit[3] = '{8'h00, 8'hA5, 8'h00};
    int p_sinit[3] = '{8'h3C, 8'h3C, 8'h3C};
    int p_prio [3] = '{1, 0, 1};

    // Reference model state
    int mq[3];
    bit busy[3];
    int mcnt[3];
    bit mdone[3];
    bit mdir[3];  // 1 = lsb_to_msb

    c_shift_sym_fd_v6_0 #(
        .C_WIDTH(8), .C_SYM_WIDTH(2), .C_SHIFT_TYPE(0), .C_FILL_DATA(0),
        .C_AINIT_VAL(8'h00), .C_SINIT_VAL(8'h3C), .C_SYNC_PRIORITY(1), .C_HAS_CE(1)
    ) u_a (
        .CLK(CLK), .ARESETN(ARESETN), .CE(CE), .SCLR(SCLR), .SINIT(SINIT),
        .LSB_2_MSB(LSB_2_MSB), .D(D), .LOAD_VALID(LOAD_VALID), .LOAD_READY(rdy_w[0]),
        .SDIN(SDIN), .SHIFT_EN(SHIFT_EN), .SDOUT(sdout_w[0]), .SDOUT_VALID(vld_w[0]),
        .Q(q_w[0]), .COUNT(cnt_w[0]), .DONE(done_w[0])
    );

    c_shift_sym_fd_v6_0 #(
        .C_WIDTH(8), .C_SYM_WIDTH(2), .C_SHIFT_TYPE(1), .C_FILL_DATA(4),
        .C_AINIT_VAL(8'hA5), .C_SINIT_VAL(8'h3C), .C_SYNC_PRIORITY(0), .C_HAS_CE(1)
    ) u_b (
        .CLK(CLK), .ARESETN(ARESETN), .CE(CE), .SCLR(SCLR), .SINIT(SINIT),
        .LSB_2_MSB(LSB_2_MSB), .D(D), .LOAD_VALID(LOAD_VALID), .LOAD_READY(rdy_w[1]),
        .SDIN(SDIN), .SHIFT_EN(SHIFT_EN), .SDOUT(sdout_w[1]), .SDOUT_VALID(vld_w[1]),
        .Q(q_w[1]), .COUNT(cnt_w[1]), .DONE(done_w[1])
    );

    c_shift_sym_fd_v6_0 #(
        .C_WIDTH(8), .C_SYM_WIDTH(2), .C_SHIFT_TYPE(2), .C_FILL_DATA(5),
        .C_AINIT_VAL(8'h00), .C_SINIT_VAL(8'h3C), .C_SYNC_PRIORITY(1), .C_HAS_CE(1)
    ) u_c (
        .CLK(CLK), .ARESETN(ARESETN), .CE(CE), .SCLR(SCLR), .SINIT(SINIT),
        .LSB_2_MSB(LSB_2_MSB), .D(D), .LOAD_VALID(LOAD_VALID), .LOAD_READY(rdy_w[2]),
        .SDIN(SDIN), .SHIFT_EN(SHIFT_EN), .SDOUT(sdout_w[2]), .SDOUT_VALID(vld_w[2]),
        .Q(q_w[2]), .COUNT(cnt_w[2]), .DONE(done_w[2])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int m_sdout(int i);
        return mdir[i] ? (mq[i] / 64) % 4 : mq[i] % 4;
    endfunction

    function automatic bit m_ready(int i);
        return !busy[i] || (SHIFT_EN && mcnt[i] == NS - 1);
    endfunction

    function automatic int m_fill(int i);
        case (p_fill[i])
            0:       return 0;
            1:       return 3;
            2:       return (mq[i] % 2 == 1) ? 3 : 0;
            3:       return (mq[i] >= 128) ? 3 : 0;
            4:       return m_sdout(i);
            default: return int'(SDIN);
        endcase
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 3; i++) begin
            mq[i] = p_ainit[i]; busy[i] = 0; mcnt[i] = 0; mdone[i] = 0; mdir[i] = 1;
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic m_clock();
        if (!ARESETN) begin
            m_reset();
            return;
        end
        for (int i = 0; i < 3; i++) begin
            bit stepping, last, ld;
            mdone[i] = 0;
            if (SCLR || SINIT) begin
                mq[i]   = (SCLR && (p_prio[i] == 1 || !SINIT)) ? 0 : p_sinit[i];
                busy[i] = 0;
                mcnt[i] = 0;
            end else begin
                stepping = busy[i] && SHIFT_EN && CE;
                last     = (mcnt[i] == NS - 1);
                ld       = LOAD_VALID && m_ready(i) && CE;
                mdone[i] = stepping && last;
                if (ld) begin
                    mq[i]   = int'(D);
                    mcnt[i] = 0;
                    busy[i] = 1;
                    mdir[i] = (p_type[i] == 2) ? LSB_2_MSB : (p_type[i] == 0);
                end else if (stepping) begin
                    int f;
                    f = m_fill(i);
                    mq[i] = mdir[i] ? (mq[i] * 4 + f) % 256 : mq[i] / 4 + f * 64;
                    if (last) begin
                        mcnt[i] = 0;
                        busy[i] = 0;
                    end else begin
                        mcnt[i]++;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("q[%0d]", i),     q_w[i],     mq[i]);
            check($sformatf("sdout[%0d]", i), sdout_w[i], m_sdout(i));
            check($sformatf("vld[%0d]", i),   vld_w[i],   busy[i]);
            check($sformatf("rdy[%0d]", i),   rdy_w[i],   m_ready(i));
            check($sformatf("cnt[%0d]", i),   cnt_w[i],   mcnt[i]);
            check($sformatf("done[%0d]", i),  done_w[i],  mdone[i]);
        end
    endtask

    task automatic settle();
        #1;
        compare_all();
    endtask

    task automatic clk_edge();
        m_clock();
        @(posedge CLK);
        #1;
    endtask

    task automatic tick();
        settle();
        clk_edge();
    endtask

    typedef struct {
        bit         lv;
        logic [7:0] d;
        bit         se;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [7:0] qa;
        logic [7:0] qb;
        bit         done;
        bit         rdy;
        bit         vld;
    } vec_t;

    vec_t tbl[7];

    initial begin
        // Load 0xB4: u_a shifts left with zeros, u_b shifts right with wrap
        tbl[0] = '{1'b1, 8'hB4, 1'b0, 2'b00, 2'b10, 8'h00, 8'hA5, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 8'h00, 1'b1, 2'b10, 2'b00, 8'hB4, 8'hB4, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 2'b11, 2'b01, 8'hD0, 8'h2D, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 2'b01, 2'b11, 8'h40, 8'h4B, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 2'b00, 2'b10, 8'h00, 8'hD2, 1'b0, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 2'b00, 2'b00, 8'h00, 8'hB4, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 2'b00, 2'b00, 8'h00, 8'hB4, 1'b0, 1'b1, 1'b0};

        ARESETN = 1'b1; CE = 1'b1; SCLR = 1'b0; SINIT = 1'b0; LSB_2_MSB = 1'b1;
        D = 8'h00; LOAD_VALID = 1'b0; SDIN = 2'b00; SHIFT_EN = 1'b0;
        #2;
        ARESETN = 1'b0;
        m_reset();
        settle();
        @(posedge CLK);
        #1;
        ARESETN = 1'b1;
        tick();

        // Directed table
        for (int r = 0; r < 7; r++) begin
            LOAD_VALID = tbl[r].lv; D = tbl[r].d; SHIFT_EN = tbl[r].se;
            settle();
            check($sformatf("tbl%0d_sdout_a", r), sdout_w[0], tbl[r].sa);
            check($sformatf("tbl%0d_sdout_b", r), sdout_w[1], tbl[r].sb);
            check($sformatf("tbl%0d_q_a", r),     q_w[0],     tbl[r].qa);
            check($sformatf("tbl%0d_q_b", r),     q_w[1],     tbl[r].qb);
            check($sformatf("tbl%0d_done_a", r),  done_w[0],  tbl[r].done);
            check($sformatf("tbl%0d_rdy_a", r),   rdy_w[0],   tbl[r].rdy);
            check($sformatf("tbl%0d_vld_b", r),   vld_w[1],   tbl[r].vld);
            clk_edge();
        end

        // Back-to-back load on the final step
        LOAD_VALID = 1'b1; D = 8'hB4; SHIFT_EN = 1'b0; tick();
        LOAD_VALID = 1'b0; SHIFT_EN = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        LOAD_VALID = 1'b1; D = 8'h5A;
        settle();
        check("b2b_ready", rdy_w[0], 1'b1);
        clk_edge();
        LOAD_VALID = 1'b0; SHIFT_EN = 1'b0;
        settle();
        check("b2b_done",  done_w[0],  1'b1);
        check("b2b_q",     q_w[0],     8'h5A);
        check("b2b_sdout", sdout_w[0], 2'b01);
        check("b2b_vld",   vld_w[0],   1'b1);
        clk_edge();
        SHIFT_EN = 1'b1;
        for (int k = 0; k < NS; k++) tick();
        SHIFT_EN = 1'b0; tick();

        // Bidirectional: direction latched at load, later toggles ignored
        LSB_2_MSB = 1'b0; SDIN = 2'b11;
        LOAD_VALID = 1'b1; D = 8'h0F; tick();
        LOAD_VALID = 1'b0; SHIFT_EN = 1'b1;
        for (int k = 0; k < NS; k++) begin
            LSB_2_MSB = (k % 2 == 0);
            tick();
        end
        SHIFT_EN = 1'b0;
        settle();
        check("bidir_q",    q_w[2],    8'hFF);
        check("bidir_done", done_w[2], 1'b1);
        clk_edge();

        // SCLR and SINIT together with CE low, mid-word
        LSB_2_MSB = 1'b1;
        LOAD_VALID = 1'b1; D = 8'hB4; tick();
        LOAD_VALID = 1'b0; SHIFT_EN = 1'b1; tick();
        CE = 1'b0; SCLR = 1'b1; SINIT = 1'b1; tick();
        CE = 1'b1; SCLR = 1'b0; SINIT = 1'b0; SHIFT_EN = 1'b0;
        settle();
        check("sync_q_prio1", q_w[0],   8'h00);
        check("sync_q_prio0", q_w[1],   8'h3C);
        check("sync_vld_a",   vld_w[0], 1'b0);
        check("sync_vld_b",   vld_w[1], 1'b0);
        check("sync_rdy_a",   rdy_w[0], 1'b1);
        clk_edge();

        // Asynchronous reset after two steps
        LOAD_VALID = 1'b1; D = 8'hB4; tick();
        LOAD_VALID = 1'b0; SHIFT_EN = 1'b1; tick(); tick();
        ARESETN = 1'b0;
        m_reset();
        #1;
        check("arst_q_a",    q_w[0],    8'h00);
        check("arst_q_b",    q_w[1],    8'hA5);
        check("arst_cnt_a",  cnt_w[0],  2'd0);
        check("arst_vld_a",  vld_w[0],  1'b0);
        check("arst_done_a", done_w[0], 1'b0);
        tick();
        settle();
        check("arst_no_done", done_w[0], 1'b0);
        ARESETN = 1'b1; LOAD_VALID = 1'b1; D = 8'hC3; SHIFT_EN = 1'b0; tick();
        LOAD_VALID = 1'b0; SHIFT_EN = 1'b1;
        settle();
        check("arst_reload_q",     q_w[0],     8'hC3);
        check("arst_reload_sdout", sdout_w[0], 2'b11);
        clk_edge();
        for (int k = 0; k < NS - 1; k++) tick();
        SHIFT_EN = 1'b0; tick();

        // Randomised traffic against the model
        for (int c = 0; c < 1500; c++) begin
            LOAD_VALID = ($urandom_range(0, 3) != 0);
            SHIFT_EN   = ($urandom_range(0, 3) != 0);
            CE         = ($urandom_range(0, 7) != 0);
            SCLR       = ($urandom_range(0, 31) == 0);
            SINIT      = ($urandom_range(0, 31) == 0);
            LSB_2_MSB  = 1'($urandom_range(0, 1));
            SDIN       = 2'($urandom_range(0, 3));
            D          = 8'($urandom_range(0, 255));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
